fifo_sync_fwft: RTL

Parametrised single-clock FIFO built on a synchronous-read RAM (one-cycle read latency, registered read data).
- First-word-fall-through valid/ready interfaces on both sides.
- Occupancy count, almost-full/almost-empty flags and a synchronous flush.
- General packet/stream buffer between TCP/IP datapath stages; replaces bare RAM-plus-pointer FIFOs.

---
 rtl/fifo_sync_fwft.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO on a read-first synchronous RAM.
// Define FIFO_PARITY_EN to store an even-parity bit per word and expose par_err/par_err_seen.
module fifo_sync_fwft #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 4,
    parameter int CBITS      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CBITS:0]   count,
    output logic             almost_full,
    output logic             almost_empty
`ifdef FIFO_PARITY_EN
    ,
    output logic             par_err,
    output logic             par_err_seen
`endif
);

`ifdef FIFO_PARITY_EN
    localparam int RW = WIDTH + 1;
`else
    localparam int RW = WIDTH;
`endif

    localparam logic [CBITS:0] DEPTH_C  = (CBITS+1)'(DEPTH);
    localparam logic [CBITS:0] AFULL_C  = (CBITS+1)'(AFULL_LVL);
    localparam logic [CBITS:0] AEMPTY_C = (CBITS+1)'(AEMPTY_LVL);

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [RW-1:0]    mem [DEPTH];
    logic [RW-1:0]    rd_q;
    logic [RW-1:0]    wr_word_s;
    logic [CBITS-1:0] wptr_q, wptr_d;
    logic [CBITS-1:0] rptr_q, rptr_d;
    logic [CBITS:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             head_ready_q, head_ready_d;
    logic             push_d1_q, push_d1_d;
    logic             push_s, pop_s;

    // Handshakes and write word assembly
    always_comb begin
        in_ready = !full_q && !clear;
        push_s   = in_valid && in_ready;
        pop_s    = head_ready_q && out_ready;
`ifdef FIFO_PARITY_EN
        wr_word_s = {even_parity(in_data), in_data};
`else
        wr_word_s = in_data;
`endif
    end

    // Next-state for pointers, occupancy, flags and head visibility
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        push_d1_d    = 1'b0;
        head_ready_d = 1'b0;
        if (clear) begin
            wptr_d  = {CBITS{1'b0}};
            rptr_d  = {CBITS{1'b0}};
            count_d = {(CBITS+1){1'b0}};
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + CBITS'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + CBITS'(1);
            end else begin
                rptr_d = rptr_q;
            end
            count_d   = count_q + (CBITS+1)'(push_s) - (CBITS+1)'(pop_s);
            push_d1_d = push_s;
            // Words written on this edge or the previous one are still in the read pipeline.
            head_ready_d = (count_d - (CBITS+1)'(push_s) - (CBITS+1)'(push_d1_q)) != {(CBITS+1){1'b0}};
        end
        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= {CBITS{1'b0}};
            rptr_q       <= {CBITS{1'b0}};
            count_q      <= {(CBITS+1){1'b0}};
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            head_ready_q <= 1'b0;
            push_d1_q    <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
            head_ready_q <= head_ready_d;
            push_d1_q    <= push_d1_d;
        end
    end

    // Read-first storage array; read address looks ahead to the post-pop head
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wptr_q] <= wr_word_s;
        end
        rd_q <= mem[rptr_d];
    end

    always_comb begin
        out_valid    = head_ready_q;
        out_data     = rd_q[WIDTH-1:0];
        count        = count_q;
        almost_full  = afull_q;
        almost_empty = aempty_q;
    end

`ifdef FIFO_PARITY_EN
    logic par_seen_q, par_seen_d;

    // Parity compare on the head word and its sticky record
    always_comb begin
        par_err = head_ready_q && (even_parity(rd_q[WIDTH-1:0]) != rd_q[WIDTH]);
        if (clear) begin
            par_seen_d = 1'b0;
        end else begin
            par_seen_d = par_seen_q || par_err;
        end
        par_err_seen = par_seen_q;
    end

    // Sticky parity error register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_seen_q <= 1'b0;
        end else begin
            par_seen_q <= par_seen_d;
        end
    end
`endif

endmodule
